// File: rtl/huffman_pkg.sv
// huffman_pkg: shared symbol width, default address width and phase encoding
package huffman_pkg;
    localparam int SYM_W  = 8;
    localparam int AW_DEF = 8;
    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_COUNT, S_BUILD, S_ENCODE, S_FLUSH, S_FIN
    } state_t;
endpackage

// File: rtl/huffman_sym_fifo.sv
// huffman_sym_fifo: 2-entry symbol FIFO with registered head and occupancy count
module huffman_sym_fifo
    import huffman_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [SYM_W-1:0] din,
    output logic [SYM_W-1:0] head,
    output logic [1:0]       count
);
    logic [SYM_W-1:0] tail;
    logic do_pop, do_push;
    assign do_pop  = pop && count != 2'd0;
    assign do_push = push && (count != 2'd2 || do_pop);
    // head always holds the oldest entry so the consumer sees it without a read cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (do_push && do_pop) begin
            if (count == 2'd2) begin
                head <= tail;
                tail <= din;
            end else begin
                head <= din;
            end
        end else if (do_pop) begin
            head  <= tail;
            count <= count - 2'd1;
        end else if (do_push) begin
            if (count == 2'd0) head <= din;
            else tail <= din;
            count <= count + 2'd1;
        end
    end
endmodule

// File: rtl/huffman_ctrl.sv
// huffman_ctrl: phase sequencer clear/count/build/encode/flush for the Huffman datapath
module huffman_ctrl
    import huffman_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [AW:0]      len,
    output logic             busy,
    output logic             done,
    output logic             src_rd,
    output logic [AW-1:0]    src_addr,
    input  logic [SYM_W-1:0] src_data,
    output logic             freq_clr,
    output logic             freq_inc,
    output logic [SYM_W-1:0] freq_sym,
    output logic             tree_start,
    input  logic             tree_done,
    output logic             enc_valid,
    output logic [SYM_W-1:0] enc_sym,
    input  logic             enc_ready,
    output logic             enc_flush,
    input  logic             flush_done
);
    localparam logic [AW:0] ONE = 1;

    state_t state, prev_state, next_state;
    logic [AW:0] len_q, rd_cnt, acc_cnt;
    logic rd_q, first, accept, room, fifo_push;
    logic [SYM_W-1:0] fifo_head;
    logic [1:0] fifo_cnt;

    // a state is on its first cycle whenever it differs from last cycle's state
    assign first     = state != prev_state;
    assign accept    = enc_valid && enc_ready;
    // a pop this cycle frees a slot, which keeps one accept per cycle sustainable
    assign room      = ({1'b0, fifo_cnt} + {2'b00, rd_q}) < (3'd2 + {2'b00, accept});
    assign fifo_push = rd_q && state == S_ENCODE;
    assign freq_inc  = rd_q && state == S_COUNT;
    assign freq_sym  = freq_inc ? src_data : '0;
    assign src_addr  = src_rd ? rd_cnt[AW-1:0] : '0;
    assign enc_valid = fifo_cnt != 2'd0;
    assign enc_sym   = enc_valid ? fifo_head : '0;

    huffman_sym_fifo u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (accept),
        .din   (src_data),
        .head  (fifo_head),
        .count (fifo_cnt)
    );

    // state register plus a one-cycle history used to detect state entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            prev_state <= S_IDLE;
        end else begin
            state      <= next_state;
            prev_state <= state;
        end
    end

    // next-state and phase strobes
    always_comb begin
        next_state = state;
        busy       = state != S_IDLE;
        done       = 1'b0;
        src_rd     = 1'b0;
        freq_clr   = 1'b0;
        tree_start = 1'b0;
        enc_flush  = 1'b0;
        case (state)
            S_IDLE:   if (start) next_state = S_CLEAR;
            S_CLEAR: begin
                freq_clr   = 1'b1;
                next_state = len_q == '0 ? S_FIN : S_COUNT;
            end
            S_COUNT: begin
                src_rd = rd_cnt < len_q;
                if (rd_q && rd_cnt == len_q) next_state = S_BUILD;
            end
            S_BUILD: begin
                tree_start = first;
                if (tree_done) next_state = S_ENCODE;
            end
            S_ENCODE: begin
                src_rd = rd_cnt < len_q && room;
                if (accept && acc_cnt + ONE == len_q) next_state = S_FLUSH;
            end
            S_FLUSH: begin
                enc_flush = first;
                if (flush_done) next_state = S_FIN;
            end
            S_FIN: begin
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default:  next_state = S_IDLE;
        endcase
    end

    // length latch, read/accept counters (one bit wider than the address so LEN=2^AW never wraps)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q   <= '0;
            rd_cnt  <= '0;
            acc_cnt <= '0;
            rd_q    <= 1'b0;
        end else begin
            rd_q <= src_rd;
            if (state == S_IDLE && start) len_q <= len;
            rd_cnt  <= src_rd ? rd_cnt + ONE : (state == S_BUILD || state == S_IDLE) ? '0 : rd_cnt;
            acc_cnt <= accept ? acc_cnt + ONE : state == S_IDLE ? '0 : acc_cnt;
        end
    end
endmodule

// File: tb/tb_huffman_ctrl.sv
// tb_huffman_ctrl: scoreboard bench for the Huffman phase sequencer
module tb_huffman_ctrl;
    localparam int AW = 8;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [AW:0] len = '0;
    logic busy, done, src_rd, freq_clr, freq_inc, tree_start, tree_done, enc_valid, enc_flush;
    logic enc_ready = 1'b1, flush_done = 1'b0;
    logic [AW-1:0] src_addr;
    logic [7:0] src_data = '0, freq_sym, enc_sym;

    huffman_ctrl #(.AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy), .done(done),
        .src_rd(src_rd), .src_addr(src_addr), .src_data(src_data),
        .freq_clr(freq_clr), .freq_inc(freq_inc), .freq_sym(freq_sym),
        .tree_start(tree_start), .tree_done(tree_done),
        .enc_valid(enc_valid), .enc_sym(enc_sym), .enc_ready(enc_ready),
        .enc_flush(enc_flush), .flush_done(flush_done)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // environment models: source memory, tree builder, flush engine
    logic [7:0] mem [256];
    int tcnt = 0, tree_d = 5;
    bit tree_lvl = 1'b0;
    int cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (src_rd) src_data <= mem[src_addr];
        flush_done <= enc_flush;
        tcnt <= tree_start ? 1 : (tcnt > 0 && tcnt < tree_d) ? tcnt + 1 : 0;
    end
    assign tree_done = tree_lvl || (tree_d > 0 && tcnt == tree_d);

    bit rmode = 1'b0;
    int pidx = 0;
    bit [6:0] pat = 7'b1101001;
    initial forever begin
        @(posedge clk);
        #1;
        enc_ready = rmode ? pat[pidx] : 1'b1;
        pidx = (pidx + 1) % 7;
    end

    logic [7:0] freq_q[$], enc_q[$];
    logic [AW:0] cur_len = '0;
    int t_start, n_clr, n_rd, n_inc, n_ts, n_fl, n_done, n_acc, n_val;
    int clr_cyc, first_rd, last_inc, ts_cyc, fl_cyc, done_cyc, first_v, first_acc, last_acc, addr_exp, last_addr;
    bit prev_v = 1'b0, prev_acc = 1'b0;
    logic [7:0] prev_sym = '0;

    always @(negedge clk) begin
        if (!rst_n) prev_v = 1'b0;
        else begin
            if (freq_clr) begin n_clr++; clr_cyc = cyc; end
            if (src_rd) begin
                if (n_rd == 0) first_rd = cyc;
                check("src_addr", src_addr, addr_exp & 255);
                check("addr_range", addr_exp < int'(cur_len), 1);
                addr_exp++;
                n_rd++;
                last_addr = src_addr;
            end
            if (freq_inc) begin
                n_inc++;
                last_inc = cyc;
                if (freq_q.size() == 0) check("freq_extra", 1, 0);
                else check("freq_sym", freq_sym, freq_q.pop_front());
            end
            if (tree_start) begin n_ts++; ts_cyc = cyc; addr_exp = 0; end
            if (enc_valid) begin n_val++; if (first_v < 0) first_v = cyc; end
            if (prev_v && !prev_acc) begin
                check("hold_valid", enc_valid, 1);
                check("hold_sym", enc_sym, prev_sym);
            end
            if (enc_valid && enc_ready) begin
                n_acc++;
                if (n_acc == 1) first_acc = cyc;
                last_acc = cyc;
                if (enc_q.size() == 0) check("enc_extra", 1, 0);
                else check("enc_sym", enc_sym, enc_q.pop_front());
            end
            if (enc_flush) begin n_fl++; fl_cyc = cyc; end
            if (done) begin n_done++; done_cyc = cyc; end
            prev_v = enc_valid;
            prev_acc = enc_valid && enc_ready;
            prev_sym = enc_sym;
        end
    end

    task automatic launch(input int l, input int d, input bit rm, input bit fixed);
        cur_len = 9'(l);
        tree_d = d;
        tree_lvl = d == 0;
        rmode = rm;
        freq_q.delete();
        enc_q.delete();
        for (int i = 0; i < l; i++) begin
            if (fixed) mem[i] = (i == 1) ? 8'h42 : (i == 3) ? 8'h43 : 8'h41;
            else mem[i] = 8'($urandom);
            freq_q.push_back(mem[i]);
            enc_q.push_back(mem[i]);
        end
        {n_clr, n_rd, n_inc, n_ts, n_fl, n_done, n_acc, n_val, addr_exp} = '0;
        {clr_cyc, ts_cyc, fl_cyc, done_cyc, first_rd, last_inc, first_acc, last_acc} = '0;
        first_v = -1;
        last_addr = -1;
        prev_v = 1'b0;
        start = 1'b1;
        len = 9'(l);
        t_start = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        len = 9'($urandom);
    endtask

    task automatic finish_run(input int l, input int d, input bit rm);
        int k = 0;
        bit act = l != 0;
        while (n_done == 0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (n_done == 0) check("done_timeout", 0, 1);
        check("n_clr", n_clr, 1);
        check("clr_cyc", clr_cyc, t_start + 1);
        check("n_done", n_done, 1);
        check("n_inc", n_inc, l);
        check("n_acc", n_acc, l);
        check("n_rd", n_rd, 2 * l);
        check("n_ts", n_ts, act);
        check("n_flush", n_fl, act);
        check("freq_q_left", freq_q.size(), 0);
        check("enc_q_left", enc_q.size(), 0);
        if (act) begin
            check("first_rd", first_rd, t_start + 2);
            check("last_inc", last_inc, t_start + 2 + l);
            check("ts_cyc", ts_cyc, t_start + 3 + l);
            check("first_valid", first_v, ts_cyc + d + 3);
            check("done_cyc", done_cyc, fl_cyc + 2);
            if (!rm) check("throughput", last_acc - first_acc, l - 1);
        end else begin
            check("done_len0", done_cyc, t_start + 2);
            check("valid_len0", n_val, 0);
        end
        @(posedge clk);
        #1;
        check("busy_after", busy, 0);
        check("done_pulse", done, 0);
    endtask

    initial begin
        int k;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outs", {busy, done, src_rd, src_addr, freq_clr, freq_inc, freq_sym,
                           tree_start, enc_valid, enc_sym, enc_flush}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        launch(4, 5, 1'b0, 1'b1);
        finish_run(4, 5, 1'b0);
        launch(4, 5, 1'b1, 1'b0);
        finish_run(4, 5, 1'b1);
        launch(0, 5, 1'b0, 1'b0);
        finish_run(0, 5, 1'b0);
        launch(256, 0, 1'b0, 1'b0);
        finish_run(256, 0, 1'b0);
        check("last_addr", last_addr, 8'hFF);
        launch(256, 3, 1'b1, 1'b0);
        finish_run(256, 3, 1'b1);
        launch(5, 20, 1'b0, 1'b0);
        k = 0;
        while (n_ts == 0 && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (n_ts == 0) check("ts_timeout", 0, 1);
        @(posedge clk);
        #1;
        start = 1'b1;
        len = 9'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        finish_run(5, 20, 1'b0);
        launch(4, 2, 1'b0, 1'b0);
        k = 0;
        while (n_acc < 2 && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (n_acc < 2) check("acc_timeout", 0, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_outs", {busy, done, src_rd, src_addr, freq_clr, freq_inc, freq_sym,
                               tree_start, enc_valid, enc_sym, enc_flush}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_rst", busy, 0);
        launch(4, 5, 1'b0, 1'b1);
        finish_run(4, 5, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
